fetch_queue: RTL and testbench

//  Instruction-fetch front end: owns the PC, issues in-order requests to instruction memory, buffers returned

---
 rtl/mips_pkg.sv | 19 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path constants, the queue entry layout and the PC increment helper.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          ADDR_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO with push/pop/flush and an occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, credit-limited imem requests, instruction queue and redirect flush.
// Optional FETCH_QUEUE_STATS_EN adds starvation and flush counters.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_incr
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stat_starve,
    output logic [31:0] stat_flush
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_addr;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W:0]    in_use;
    logic              q_full;
    logic              q_empty;
    logic              a_full;
    logic              a_empty;
    logic              issue;
    logic              rsp_keep;
    logic              pop;
    fetch_entry_t      q_din;
    fetch_entry_t      q_dout;

    // Queue slots and in-flight requests share one credit pool, so a response always has room.
    assign in_use   = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req = rst && !redirect_valid && !q_full && !a_full
                      && (in_use < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_ready;

    assign rsp_keep = imem_rvalid && !a_empty && (drop_cnt == '0) && !redirect_valid;
    assign q_din    = '{pc: rsp_addr, instr: imem_rdata};
    assign pop      = !q_empty && instr_ready;

    assign instr_valid   = !q_empty;
    assign instr         = q_empty ? NOP   : q_dout.instr;
    assign instr_pc      = q_empty ? '0    : q_dout.pc;
    assign instr_pc_incr = q_empty ? '0    : pc_next(q_dout.pc);

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (imem_rvalid),
        .flush (1'b0),
        .din   (fetch_pc),
        .dout  (rsp_addr),
        .count (outstanding),
        .full  (a_full),
        .empty (a_empty)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (issue) begin
            fetch_pc <= pc_next(fetch_pc);
        end
    end

    // On redirect every request still in flight after this cycle's response becomes a drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - CNT_W'(imem_rvalid);
        end else if (imem_rvalid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_starve <= '0;
            stat_flush  <= '0;
        end else begin
            if (instr_ready && q_empty && !redirect_valid && (stat_starve != '1))
                stat_starve <= stat_starve + 1'b1;
            if (redirect_valid && (stat_flush != '1))
                stat_flush <= stat_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with an in-order variable-latency memory model.
// Build with FETCH_QUEUE_STATS_EN to also check the statistics counters.
module tb_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_incr;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_starve;
    logic [31:0] stat_flush;
`endif

    word_t       exp_q[$];
    req_t        pend[$];
    logic [31:0] model_pc = '0;
    int          epoch = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        in_reset = 1'b1;
    logic        issued;
    logic        valid_pre;
    int          starve_m = 0;
    int          flush_m = 0;

    int          p_ready = 100;
    int          p_iready = 100;
    int          p_redirect = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        redir_fixed = 1'b0;
    logic [31:0] redir_target = '0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_incr  (instr_pc_incr)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_starve    (stat_starve),
        .stat_flush     (stat_flush)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle request-side checks, taken before the edge commits.
    task automatic check_output();
        logic exp_req;
        exp_req = !redirect_valid && ((exp_q.size() + pend.size()) < 4);
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (imem_req) check("imem_addr", imem_addr, model_pc);
`ifdef FETCH_QUEUE_STATS_EN
        check("stat_starve", stat_starve, starve_m);
        check("stat_flush", stat_flush, flush_m);
`endif
        issued    = imem_req && imem_ready;
        valid_pre = (exp_q.size() != 0);
    endtask

    task automatic apply_stimulus(input int n);
        req_t r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            redirect_valid = ($urandom_range(99) < p_redirect);
            redirect_pc    = redir_fixed ? redir_target : ($urandom() & 32'hFFFF_FFFC);
            imem_ready     = ($urandom_range(99) < p_ready);
            instr_ready    = ($urandom_range(99) < p_iready);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
            end
            #1;
            check_output();
            #2;
            if (instr_ready && !valid_pre && !redirect_valid) starve_m++;
            if (imem_rvalid) begin
                r = pend.pop_front();
                if (r.epoch == epoch && !redirect_valid)
                    exp_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc;
                epoch++;
                flush_m++;
            end else if (issued) begin
                pend.push_back('{addr: model_pc, epoch: epoch,
                                 due: cyc + int'($urandom_range(lat_max, lat_min))});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    // Asserts reset off the clock edge and checks the outputs clear at once.
    task automatic do_reset();
        #1;
        rst      = 1'b0;
        in_reset = 1'b1;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_instr_pc_incr", instr_pc_incr, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        check("rst_stat_starve", stat_starve, 32'd0);
        check("rst_stat_flush", stat_flush, 32'd0);
`endif
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        instr_ready    = 1'b0;
        exp_q.delete();
        pend.delete();
        model_pc = 32'h0000_0000;
        starve_m = 0;
        flush_m  = 0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic one_redirect(input logic [31:0] target);
        redir_fixed  = 1'b1;
        redir_target = target;
        p_redirect   = 100;
        apply_stimulus(1);
        p_redirect   = 0;
        redir_fixed  = 1'b0;
    endtask

    // Monitor: compares the queue head against the scoreboard and retires it on handshake.
    always @(negedge clk) begin
        #2;
        if (!in_reset) begin
            check("instr_valid", {31'b0, instr_valid}, {31'b0, (exp_q.size() != 0)});
            if (instr_valid && exp_q.size() != 0) begin
                check("instr", instr, exp_q[0].data);
                check("instr_pc", instr_pc, exp_q[0].pc);
                check("instr_pc_incr", instr_pc_incr, exp_q[0].pc + 32'd4);
                if (instr_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2;
        do_reset();

        p_ready = 100; p_iready = 100; lat_min = 1; lat_max = 1;
        apply_stimulus(20);

        p_iready = 0;
        apply_stimulus(10);
        p_iready = 100;
        apply_stimulus(10);

        lat_min = 2; lat_max = 2;
        apply_stimulus(5);
        one_redirect(32'h0000_0100);
        apply_stimulus(10);

        lat_min = 1; lat_max = 1;
        apply_stimulus(8);
        one_redirect(32'h0000_0020);
        apply_stimulus(10);

        one_redirect(32'hFFFF_FFF0);
        apply_stimulus(12);

        p_ready = 0; p_iready = 100;
        apply_stimulus(5);
        p_ready = 100;
        for (int k = 0; k < 3; k++) one_redirect(32'h0000_0400 + 32'(k * 16));
        apply_stimulus(10);

        p_ready = 70; p_iready = 60; p_redirect = 8; lat_min = 1; lat_max = 4;
        apply_stimulus(3000);

        p_redirect = 0; p_ready = 100; p_iready = 0;
        apply_stimulus(12);
        do_reset();
        p_iready = 100; lat_min = 1; lat_max = 3;
        apply_stimulus(30);

        p_ready = 80; p_iready = 70; p_redirect = 30;
        apply_stimulus(500);
        p_redirect = 0;
        apply_stimulus(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
